uart_tx_fifo: RTL and testbench

Parametrised next-generation UART transmitter with an integrated TX FIFO and an on-block baud divider.
- Runtime-selectable data length (5..DATA_W bits), four parity modes and 1/2 stop bits.
- Sits between the UART register interface (push side) and the pad (tx_out).
- Frames stream back-to-back while the FIFO holds data.

---
 rtl/uart_tx_fifo.sv | 216 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an integrated TX FIFO and baud divider.
// Runtime data length (5..DATA_W), parity none/even/odd/mark, 1 or 2 stop bits.
// Optional build macro UART_TX_CTS_EN adds a cts_n flow-control input.
// dbg_state exposes the FSM state for checkers.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk_uart,
  input  logic              rst,
`ifdef UART_TX_CTS_EN
  input  logic              cts_n,
`endif
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        data_len,
  input  logic [1:0]        parity_mode,
  input  logic              stop_bit,
  input  logic [DIV_W-1:0]  baud_div,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              wr_ovf,
  output logic [2:0]        dbg_state
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LVL_W-1:0]    level;
  logic                push, pop, cts_ok, last_cycle, tx_q;
  logic [3:0]          eff_len, len_q, bit_cnt;
  logic [DATA_W-1:0]   shreg;
  logic [1:0]          par_q;
  logic                stop_q, stop_cnt, par_acc;
  logic [DIV_W-1:0]    div_q, baud_cnt;

  // Push handshake: wr_en acts as valid, (!fifo_full || pop) as ready; there is
  // no backpressure, so a push without ready is dropped and flagged on wr_ovf.
  assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  assign fifo_level = level;
  assign push       = wr_en && (!fifo_full || pop);

`ifdef UART_TX_CTS_EN
  logic cts_s1, cts_s2;
  // Two-flop synchroniser for the asynchronous clear-to-send input.
  always_ff @(posedge clk_uart or negedge rst) begin
    if (!rst) begin
      cts_s1 <= 1'b1;
      cts_s2 <= 1'b1;
    end else begin
      cts_s1 <= cts_n;
      cts_s2 <= cts_s1;
    end
  end
  assign cts_ok = ~cts_s2;
`else
  assign cts_ok = 1'b1;
`endif

  // Final cycle of the last stop bit: the slot where a back-to-back pop happens.
  assign last_cycle = (state == S_STOP) && (baud_cnt == '0) && (stop_cnt == stop_q);
  assign pop        = !fifo_empty && cts_ok && ((state == S_IDLE) || last_cycle);

  // Clamp the requested data length into 5..DATA_W.
  always_comb begin
    eff_len = data_len;
    if (data_len < 4'd5)               eff_len = 4'd5;
    else if (data_len > 4'(DATA_W))    eff_len = 4'(DATA_W);
  end

  // FIFO storage; written only, never reset.
  always_ff @(posedge clk_uart) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers, occupancy and overflow pulse.
  always_ff @(posedge clk_uart or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      wr_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (!push && pop) level <= level - LVL_W'(1);
      wr_ovf <= wr_en && fifo_full && !pop;
    end
  end

  // Frame FSM: latches config at pop, shifts bits out, pulses tx_done in the
  // last stop-bit cycle (registered one cycle ahead of that slot).
  always_ff @(posedge clk_uart or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      tx_q     <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      shreg    <= '0;
      len_q    <= 4'd5;
      par_q    <= 2'd0;
      stop_q   <= 1'b0;
      div_q    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      par_acc  <= 1'b0;
      stop_cnt <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (pop) begin
        state    <= S_START;
        shreg    <= mem[rd_ptr];
        len_q    <= eff_len;
        par_q    <= parity_mode;
        stop_q   <= stop_bit;
        div_q    <= baud_div;
        baud_cnt <= baud_div;
        tx_q     <= 1'b0;
        tx_busy  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            tx_q    <= 1'b1;
            tx_busy <= 1'b0;
          end
          S_START: begin
            if (baud_cnt == '0) begin
              state    <= S_DATA;
              tx_q     <= shreg[0];
              par_acc  <= shreg[0];
              shreg    <= shreg >> 1;
              bit_cnt  <= 4'd1;
              baud_cnt <= div_q;
            end else begin
              baud_cnt <= baud_cnt - DIV_W'(1);
            end
          end
          S_DATA: begin
            if (baud_cnt != '0) begin
              baud_cnt <= baud_cnt - DIV_W'(1);
            end else if (bit_cnt != len_q) begin
              tx_q     <= shreg[0];
              par_acc  <= par_acc ^ shreg[0];
              shreg    <= shreg >> 1;
              bit_cnt  <= bit_cnt + 4'd1;
              baud_cnt <= div_q;
            end else if (par_q != 2'd0) begin
              state    <= S_PARITY;
              tx_q     <= (par_q == 2'd1) ? par_acc :
                          (par_q == 2'd2) ? ~par_acc : 1'b1;
              baud_cnt <= div_q;
            end else begin
              state    <= S_STOP;
              tx_q     <= 1'b1;
              stop_cnt <= 1'b0;
              baud_cnt <= div_q;
              if (div_q == '0 && !stop_q) tx_done <= 1'b1;
            end
          end
          S_PARITY: begin
            if (baud_cnt != '0) begin
              baud_cnt <= baud_cnt - DIV_W'(1);
            end else begin
              state    <= S_STOP;
              tx_q     <= 1'b1;
              stop_cnt <= 1'b0;
              baud_cnt <= div_q;
              if (div_q == '0 && !stop_q) tx_done <= 1'b1;
            end
          end
          S_STOP: begin
            if (baud_cnt != '0) begin
              baud_cnt <= baud_cnt - DIV_W'(1);
              if (baud_cnt == DIV_W'(1) && stop_cnt == stop_q) tx_done <= 1'b1;
            end else if (stop_cnt != stop_q) begin
              stop_cnt <= 1'b1;
              baud_cnt <= div_q;
              if (div_q == '0) tx_done <= 1'b1;
            end else begin
              state   <= S_IDLE;
              tx_q    <= 1'b1;
              tx_busy <= 1'b0;
            end
          end
          default: begin
            state   <= S_IDLE;
            tx_q    <= 1'b1;
            tx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx_out    = tx_q | ~rst;
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed stimulus for uart_tx_fifo, checked
// cycle by cycle against a frame-waveform reference model.
module tb_uart_tx_fifo;
  localparam int DW   = 8;
  localparam int D    = 4;
  localparam int DIVW = 16;
  localparam int LW   = $clog2(D + 1);

  logic            clk_uart;
  logic            rst;
  logic            wr_en;
  logic [DW-1:0]   wr_data;
  logic [3:0]      data_len;
  logic [1:0]      parity_mode;
  logic            stop_bit;
  logic [DIVW-1:0] baud_div;
  logic            tx_out, tx_busy, tx_done, fifo_full, fifo_empty, wr_ovf;
  logic [LW-1:0]   fifo_level;
  logic [2:0]      dbg_state;

  int errors = 0;
  int checks = 0;

  uart_tx_fifo #(.DATA_W(DW), .FIFO_DEPTH(D), .DIV_W(DIVW)) dut (
    .clk_uart(clk_uart), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .data_len(data_len), .parity_mode(parity_mode), .stop_bit(stop_bit),
    .baud_div(baud_div), .tx_out(tx_out), .tx_busy(tx_busy), .tx_done(tx_done),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
    .wr_ovf(wr_ovf), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk_uart = 1'b0;
  always #5 clk_uart = ~clk_uart;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue of words, the line as a queue of
  // per-cycle levels built from a whole frame at the moment it is popped.
  logic [DW-1:0] exp_q[$];
  logic          line_q[$];
  logic          e_tx = 1'b1, e_busy = 1'b0, e_done = 1'b0, e_ovf = 1'b0;
  int            e_level = 0;

  function automatic void build_frame(input logic [DW-1:0] d, input int len_raw,
                                      input int pm, input int sb, input int div);
    int   len;
    logic bits[$];
    logic p;
    len = (len_raw < 5) ? 5 : (len_raw > DW) ? DW : len_raw;
    p = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < len; i++) begin
      bits.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pm == 1) bits.push_back(p);
    if (pm == 2) bits.push_back(~p);
    if (pm == 3) bits.push_back(1'b1);
    bits.push_back(1'b1);
    if (sb != 0) bits.push_back(1'b1);
    foreach (bits[k])
      for (int r = 0; r <= div; r++) line_q.push_back(bits[k]);
  endfunction

  always @(posedge clk_uart or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      line_q.delete();
      e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_ovf = 1'b0; e_level = 0;
    end else begin
      int cnt;
      bit do_pop;
      cnt = exp_q.size();
      do_pop = 1'b0;
      if (line_q.size() == 0 && cnt > 0) begin
        do_pop = 1'b1;
        build_frame(exp_q.pop_front(), int'(data_len), int'(parity_mode),
                    int'(stop_bit), int'(baud_div));
      end
      if (line_q.size() > 0) begin
        e_tx = line_q.pop_front();
        e_busy = 1'b1;
      end else begin
        e_tx = 1'b1;
        e_busy = 1'b0;
      end
      e_done = e_busy && (line_q.size() == 0);
      e_ovf = wr_en && (cnt == D) && !do_pop;
      if (wr_en && (cnt < D || do_pop)) exp_q.push_back(wr_data);
      e_level = exp_q.size();
    end
  end

  // Per-cycle comparison and directed counters, sampled on the falling edge.
  int busy_cnt = 0, done_cnt = 0, ovf_cnt = 0, max_level = 0;
  always @(negedge clk_uart) begin
    check("tx_out", tx_out, e_tx);
    check("tx_busy", tx_busy, e_busy);
    check("tx_done", tx_done, e_done);
    check("wr_ovf", wr_ovf, e_ovf);
    check("fifo_level", fifo_level, e_level);
    check("fifo_full", fifo_full, e_level == D);
    check("fifo_empty", fifo_empty, e_level == 0);
    if (tx_busy) busy_cnt++;
    if (tx_done) done_cnt++;
    if (wr_ovf) ovf_cnt++;
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
  end

  // Driver tasks (called at a falling edge, return at a falling edge)
  task automatic clear_counters();
    busy_cnt = 0; done_cnt = 0; ovf_cnt = 0; max_level = 0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    wr_en = 1'b1;
    wr_data = d;
    @(negedge clk_uart);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while ((tx_busy || !fifo_empty || e_busy || e_level > 0) && n < max_cycles) begin
      @(negedge clk_uart);
      n++;
    end
    check("wait_timeout", n < max_cycles, 1'b1);
    @(negedge clk_uart);
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = '0;
    data_len = 4'd8; parity_mode = 2'd0; stop_bit = 1'b0; baud_div = 16'd3;
    repeat (3) @(negedge clk_uart);
    check("reset_tx_out", tx_out, 1'b1);
    check("reset_level", fifo_level, 0);
    #2 rst = 1'b1;
    @(negedge clk_uart);

    // 8N1, four cycles per bit
    clear_counters();
    push(8'h55);
    wait_idle(200);
    check("8n1_busy_cycles", busy_cnt, 40);
    check("8n1_done_pulses", done_cnt, 1);

    // 7-bit data with each parity mode; bit 7 must not affect parity
    data_len = 4'd7;
    for (int pm = 1; pm <= 3; pm++) begin
      parity_mode = 2'(pm);
      push(8'h07);
      wait_idle(200);
      push(8'h87);
      wait_idle(200);
    end
    data_len = 4'd8; parity_mode = 2'd0;

    // Overflow: six consecutive pushes into a depth-4 FIFO
    baud_div = 16'd15;
    clear_counters();
    for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
    wait_idle(2000);
    check("ovf_pulses", ovf_cnt, 1);
    check("ovf_max_level", max_level, D);
    check("ovf_frames", done_cnt, 5);

    // Back-to-back 8N2 at one cycle per bit
    baud_div = 16'd0; stop_bit = 1'b1;
    clear_counters();
    push(8'h3C);
    push(8'hC3);
    wait_idle(200);
    check("b2b_busy_cycles", busy_cnt, 22);
    check("b2b_done_pulses", done_cnt, 2);

    // Config change during DATA affects only the next frame
    baud_div = 16'd3; stop_bit = 1'b0;
    clear_counters();
    push(8'h96);
    push(8'h69);
    repeat (12) @(negedge clk_uart);
    stop_bit = 1'b1; baud_div = 16'd1;
    wait_idle(400);
    check("cfg_busy_cycles", busy_cnt, 40 + 22);
    baud_div = 16'd3; stop_bit = 1'b0;

    // Reset in the middle of DATA, then a clean frame
    push(8'h5A);
    push(8'h11);
    repeat (10) @(negedge clk_uart);
    #2 rst = 1'b0;
    #1;
    check("midrst_tx_out", tx_out, 1'b1);
    check("midrst_level", fifo_level, 0);
    check("midrst_busy", tx_busy, 1'b0);
    @(negedge clk_uart);
    #2 rst = 1'b1;
    @(negedge clk_uart);
    clear_counters();
    push(8'hA5);
    wait_idle(200);
    check("postrst_busy_cycles", busy_cnt, 40);
    check("postrst_done", done_cnt, 1);

    // Randomized traffic with random config changes
    for (int c = 0; c < 600; c++) begin
      wr_en = ($urandom_range(0, 2) == 0);
      wr_data = DW'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        data_len    = 4'($urandom_range(0, 15));
        parity_mode = 2'($urandom_range(0, 3));
        stop_bit    = 1'($urandom_range(0, 1));
        baud_div    = DIVW'($urandom_range(0, 2));
      end
      @(negedge clk_uart);
    end
    wr_en = 1'b0;
    wait_idle(5000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
